// File: rtl/clk_rst_pkg.sv
// Shared types for the board clock/reset manager: FSM state encoding,
// reset-cause codes and a counter-width helper.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_SOFT = 2'b10
  } cause_t;

  localparam logic [7:0] RESET_COUNT_MAX = 8'hFF;

  // Bits needed to hold 0..max_val without wrapping (never narrower than 1).
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Board button conditioner: two-flop synchroniser, polarity normalisation
// and a stable-count debouncer producing a clean active-high pressed level.
module debouncer
  import clk_rst_pkg::*;
#(
  parameter int unsigned CYCLES      = 16,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pressed
);

  localparam int unsigned     CW         = cnt_bits(CYCLES);
  localparam logic [CW-1:0]   LAST       = CW'(CYCLES - 1);
  localparam logic            IDLE_LEVEL = ~ACTIVE_HIGH;

  logic          sync_q1;
  logic          sync_q2;
  logic          sample;
  logic [CW-1:0] stable_cnt;

  assign sample = ACTIVE_HIGH ? sync_q2 : ~sync_q2;

  // Level flips only after CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1    <= IDLE_LEVEL;
      sync_q2    <= IDLE_LEVEL;
      stable_cnt <= '0;
      pressed    <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      if (sample == pressed) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        pressed    <= sample;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_rst_manager.sv
// Clock-and-reset manager: divides the board clock, debounces the reset
// button and sequences POR/button/soft resets onto divided-clock boundaries.
module clk_rst_manager
  import clk_rst_pkg::*;
#(
  parameter int unsigned DIV_RATIO       = 2,
  parameter int unsigned BOOT_CYCLES     = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STRETCH_CYCLES  = 20,
  parameter bit          BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_reset,
  input  logic       soft_reset_req,
  output logic       clk_o,
  output logic       clk_en,
  output logic       reset_o,
  output logic       locked,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count
);

  localparam int unsigned   DW       = cnt_bits(DIV_RATIO - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATIO - 1);
  localparam logic [DW-1:0] DIV_HIGH = DW'(DIV_RATIO / 2);

  localparam int unsigned   HOLD_MAX   = (BOOT_CYCLES > STRETCH_CYCLES) ?
                                         BOOT_CYCLES : STRETCH_CYCLES;
  localparam int unsigned   HW         = cnt_bits(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_SAT   = HW'(HOLD_MAX);
  localparam logic [HW-1:0] BOOT_TH    = HW'(BOOT_CYCLES);
  localparam logic [HW-1:0] STRETCH_TH = HW'(STRETCH_CYCLES);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          btn_pressed;
  logic          req_any;
  state_t        state;
  logic [HW-1:0] hold_cnt;
  cause_t        cause_q;

  debouncer #(
    .CYCLES      (DEBOUNCE_CYCLES),
    .ACTIVE_HIGH (BTN_ACTIVE_HIGH)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_reset),
    .pressed (btn_pressed)
  );

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // clk_o/clk_en are registered from the next count so they track div_cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      clk_o   <= 1'b0;
      clk_en  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      clk_o   <= (div_nxt >= DIV_HIGH);
      clk_en  <= (div_nxt == DIV_LAST);
    end
  end

  assign req_any     = btn_pressed | soft_reset_req;
  assign reset_cause = cause_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      hold_cnt    <= '0;
      reset_o     <= 1'b1;
      locked      <= 1'b0;
      cause_q     <= CAUSE_POR;
      reset_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
          if ((hold_cnt >= BOOT_TH) && clk_en) begin
            state   <= RUN;
            reset_o <= 1'b0;
            locked  <= 1'b1;
          end
        end
        RUN: begin
          if (req_any) begin
            state    <= HOLD;
            hold_cnt <= '0;
            reset_o  <= 1'b1;
            locked   <= 1'b0;
            cause_q  <= btn_pressed ? CAUSE_BTN : CAUSE_SOFT;
            if (reset_count != RESET_COUNT_MAX) reset_count <= reset_count + 1'b1;
          end
        end
        HOLD: begin
          if (req_any) begin
            hold_cnt <= '0;
          end else begin
            if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
            if ((hold_cnt >= STRETCH_TH) && clk_en) begin
              state   <= RUN;
              reset_o <= 1'b0;
              locked  <= 1'b1;
            end
          end
        end
        default: begin
          state   <= BOOT;
          reset_o <= 1'b1;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule
